// File: rtl/frame_pad_stream.sv
// frame_pad_stream: surrounds one raster-ordered W x H frame with a border of
// B = (K-1)/2 constant pad pixels, so the output is (W+2B) x (H+2B) pixels.
// K is picked per frame from `mode`. The source is stalled (iReady low) while
// border pixels are inserted.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   newFrame  frame start pulse, sampled only while idle
//   mode      kernel select latched on accepted newFrame (0:K3 1:K5 2:K7 3:bypass)
//   iValid    input pixel valid
//   iData     input pixel, channel 0 in the MSBs
//   iReady    block is in the active-pixel segment and accepts iData
//   oValid    oData holds a padded-frame pixel
//   oData     padded-frame pixel
//   oDone     one-cycle pulse alongside the last output pixel of a frame
//   busy      frame in progress (held through the oDone cycle)
module frame_pad_stream #(
  parameter int unsigned       WIDTH     = 320,
  parameter int unsigned       HEIGHT    = 240,
  parameter int unsigned       CHANNELS  = 3,
  parameter int unsigned       DATA_W    = 8,
  parameter logic [DATA_W-1:0] PAD_VALUE = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         newFrame,
  input  logic [1:0]                   mode,
  input  logic                         iValid,
  input  logic [CHANNELS*DATA_W-1:0]   iData,
  output logic                         iReady,
  output logic                         oValid,
  output logic [CHANNELS*DATA_W-1:0]   oData,
  output logic                         oDone,
  output logic                         busy
);

  localparam int unsigned PIX_W   = CHANNELS * DATA_W;
  localparam int unsigned MAX_DIM = (WIDTH > HEIGHT) ? WIDTH : HEIGHT;
  localparam int unsigned CNT_W   = $clog2(MAX_DIM + 7);
  localparam logic [PIX_W-1:0] PAD_PIX = {CHANNELS{PAD_VALUE}};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TOP,
    ST_LEFT,
    ST_DATA,
    ST_RIGHT,
    ST_BOTTOM
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] x_cnt, x_next;
  logic [CNT_W-1:0] y_cnt, y_next;
  logic [1:0]       b_q, b_next;

  logic             emit_pad;
  logic             emit_data;
  logic             done_set;
  logic             ovalid_next;
  logic [PIX_W-1:0] odata_next;
  logic             iready_next;
  logic             busy_next;

  // Segment end values derived from the latched border width.
  logic [CNT_W-1:0] b_ext;
  logic [CNT_W-1:0] b_last;
  logic [CNT_W-1:0] w_last;
  logic [CNT_W-1:0] row_last;
  logic [CNT_W-1:0] act_last;
  logic [CNT_W-1:0] frm_last;

  assign b_ext    = CNT_W'(b_q);
  assign b_last   = b_ext - CNT_W'(1);
  assign w_last   = CNT_W'(WIDTH - 1);
  assign row_last = CNT_W'(WIDTH - 1) + (b_ext << 1);
  assign act_last = b_ext + CNT_W'(HEIGHT - 1);
  assign frm_last = CNT_W'(HEIGHT - 1) + (b_ext << 1);

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      x_cnt  <= '0;
      y_cnt  <= '0;
      b_q    <= 2'd0;
      iReady <= 1'b0;
      oValid <= 1'b0;
      oData  <= '0;
      oDone  <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_next;
      x_cnt  <= x_next;
      y_cnt  <= y_next;
      b_q    <= b_next;
      iReady <= iready_next;
      oValid <= ovalid_next;
      oData  <= odata_next;
      oDone  <= done_set;
      busy   <= busy_next;
    end
  end

  // Next-state, counter advance and output decode.
  // Every pixel decided in cycle t is visible in t+1, so accepting newFrame
  // already issues the first top-border pixel and TOP resumes at column 1.
  always_comb begin
    state_next  = state;
    x_next      = x_cnt;
    y_next      = y_cnt;
    b_next      = b_q;
    emit_pad    = 1'b0;
    emit_data   = 1'b0;
    done_set    = 1'b0;
    ovalid_next = 1'b0;
    odata_next  = oData;
    iready_next = 1'b0;
    busy_next   = 1'b0;

    case (state)
      ST_IDLE: begin
        // busy still high means the previous frame's oDone is on the output
        if (newFrame && !busy) begin
          x_next = '0;
          y_next = '0;
          if (mode == 2'd3) begin
            b_next     = 2'd0;
            state_next = ST_DATA;
          end else begin
            b_next     = mode + 2'd1;
            emit_pad   = 1'b1;
            x_next     = CNT_W'(1);
            state_next = ST_TOP;
          end
        end
      end

      ST_TOP: begin
        emit_pad = 1'b1;
        if (x_cnt == row_last) begin
          x_next = '0;
          y_next = y_cnt + CNT_W'(1);
          if (y_cnt == b_last) state_next = ST_LEFT;
        end else begin
          x_next = x_cnt + CNT_W'(1);
        end
      end

      ST_LEFT: begin
        emit_pad = 1'b1;
        if (x_cnt == b_last) begin
          x_next     = '0;
          state_next = ST_DATA;
        end else begin
          x_next = x_cnt + CNT_W'(1);
        end
      end

      ST_DATA: begin
        if (iValid && iReady) begin
          emit_data = 1'b1;
          if (x_cnt == w_last) begin
            x_next = '0;
            if (b_q != 2'd0) begin
              state_next = ST_RIGHT;
            end else if (y_cnt == act_last) begin
              // passthrough: last pixel of the frame
              y_next     = '0;
              done_set   = 1'b1;
              state_next = ST_IDLE;
            end else begin
              y_next = y_cnt + CNT_W'(1);
            end
          end else begin
            x_next = x_cnt + CNT_W'(1);
          end
        end
      end

      ST_RIGHT: begin
        emit_pad = 1'b1;
        if (x_cnt == b_last) begin
          x_next     = '0;
          y_next     = y_cnt + CNT_W'(1);
          state_next = (y_cnt == act_last) ? ST_BOTTOM : ST_LEFT;
        end else begin
          x_next = x_cnt + CNT_W'(1);
        end
      end

      ST_BOTTOM: begin
        emit_pad = 1'b1;
        if (x_cnt == row_last) begin
          x_next = '0;
          if (y_cnt == frm_last) begin
            y_next     = '0;
            done_set   = 1'b1;
            state_next = ST_IDLE;
          end else begin
            y_next = y_cnt + CNT_W'(1);
          end
        end else begin
          x_next = x_cnt + CNT_W'(1);
        end
      end

      default: begin
        state_next = ST_IDLE;
        x_next     = '0;
        y_next     = '0;
      end
    endcase

    ovalid_next = emit_pad | emit_data;
    if (emit_data)     odata_next = iData;
    else if (emit_pad) odata_next = PAD_PIX;
    iready_next = (state_next == ST_DATA);
    // busy covers the oDone cycle so a newFrame there is not taken early
    busy_next   = (state_next != ST_IDLE) | done_set;
  end

endmodule

// File: doc/frame_pad_stream.md
# frame_pad_stream

Parametrised border-padding stage that sits between a pixel source (demosaic or frame reader) and a KxK neighbourhood filter. It takes one raster-ordered frame of W x H multi-channel pixels and emits the padded frame of (W+2B) x (H+2B) pixels, where B = (K-1)/2. K is selected per frame at run time. It stalls the source with `iReady` while it inserts border pixels, so no pixel is dropped and no external skip counting is needed.

## Interface
- `WIDTH`, 320, active pixels per row (>= 1)
- `HEIGHT`, 240, active rows per frame (>= 1)
- `CHANNELS`, 3, colour channels per pixel (>= 1)
- `DATA_W`, 8, bits per channel
- `PAD_VALUE`, 0, per-channel value of every border pixel, replicated across all channels

Ports:
- `clk`  in  1  clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `newFrame`  in  1  single-cycle frame start; sampled only in IDLE.
- `mode`  in  2  kernel select, latched on the accepted `newFrame`: 0 -> K=3 (B=1), 1 -> K=5 (B=2), 2 -> K=7 (B=3), 3 -> passthrough (B=0).
- `iValid`  in  1  `iData` holds a valid pixel.
- `iData`  in  CHANNELS*DATA_W  input pixel, channel 0 in the MSBs.
- `iReady`  out  1  block accepts `iData` this cycle; a transfer occurs when `iValid & iReady`.
- `oValid`  out  1  `oData` holds a padded-frame pixel; downstream always accepts.
- `oData`  out  CHANNELS*DATA_W  output pixel.
- `oDone`  out  1  high for exactly one cycle, coincident with the last output pixel of the frame.
- `busy`  out  1  a frame is in progress (state is not IDLE).

## Operation
- Reset values: state IDLE, all counters 0, `oValid`=0, `oData`=0, `oDone`=0, `iReady`=0, `busy`=0, latched B=0.
- Internal state: FSM plus `xCnt` (column within the current segment) and `yCnt` (padded row index).
- FSM states:
  - IDLE: leaves on `newFrame` and latches B from `mode`. Goes to TOP if B>0, else to DATA.
  - TOP: emits B rows of W+2B pad pixels, one per cycle. Then goes to LEFT.
  - LEFT: emits B pad pixels. Then goes to DATA.
  - DATA: `iReady`=1. Each accepted pixel is emitted. Cycles with no transfer emit nothing (`oValid`=0). After W accepted pixels, goes to RIGHT, or to the next row's LEFT/DATA when B=0.
  - RIGHT: emits B pad pixels. After the last active row goes to BOTTOM; otherwise goes to LEFT.
  - BOTTOM: emits B rows of W+2B pad pixels. Then goes to IDLE. With B=0 the block returns to IDLE directly from DATA after pixel W*H.
- `iReady` is decoded only from the registered state (DATA), never combinationally from `iValid`.
- `iValid` outside DATA is ignored; no data is consumed.
- `newFrame` while busy is ignored. `mode` changes mid-frame have no effect.
- Pad pixel value: `PAD_VALUE` on every channel.
- Counter widths: `$clog2(max(WIDTH,HEIGHT)+7)` bits.
- Output count per frame: exactly (WIDTH+2B)*(HEIGHT+2B) `oValid` cycles.
- Asynchronous reset mid-frame immediately forces the reset values. A partial frame is abandoned and a fresh `newFrame` is required.

## Timing
- All outputs are registered.
- Data latency: an input transfer in cycle t gives `oValid`=1 and `oData`=`iData` in cycle t+1.
- Pad emission: 1 pixel/cycle with no bubbles.
- First output pixel: one cycle after the cycle in which `newFrame` is sampled in IDLE. For B=0 this also requires an input transfer.
- Throughput: with `iValid` held at 1, output is one contiguous `oValid` burst of (W+2B)(H+2B) cycles.
- `oDone` coincides with the final `oValid`. `busy` falls in the following cycle.
- A `newFrame` in the cycle where `busy` has just fallen is accepted (back-to-back frames).

## Test plan
- WIDTH=4, HEIGHT=2, mode=0, `iValid` held at 1, pixels 1..8 -> 24 contiguous `oValid`. Rows 0 and 3 are all pad. Rows 1 and 2 are pad,1,2,3,4,pad and pad,5,6,7,8,pad. `oDone` on pixel 24. `iReady` high for exactly 8 transfer cycles.
- WIDTH=4, HEIGHT=2, mode=2, `PAD_VALUE`=8'h10 -> 80 outputs. The first 3 rows are 30 pixels of 24'h101010. Data appears at padded columns 3..6 of rows 3..4.
- mode=3 passthrough -> 8 outputs equal to inputs, each 1 cycle after its transfer. No pad pixels. `oDone` on the 8th.
- Stall: mode=0, `iValid` low for 5 cycles mid-row -> `oValid` gaps of exactly 5 cycles. Total output count stays 24 with no reordering.
- `newFrame` pulsed while busy, and `mode` toggled mid-frame -> both ignored. The frame still ends after 24 pixels.
- Reset asserted in DATA of row 1 -> next cycle all outputs are 0. A following `newFrame` gives a complete, correct 24-pixel frame.
